// File: rtl/debounce_pkg.sv
// Shared helpers and defaults for the debounce bank.
// Optional sticky change flags are built with DEBOUNCE_STICKY_EN.
package debounce_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

    function automatic int cnt_width(input int stable);
        int w;
        w = $clog2(stable + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, edge pulses.
// Sticky event flag is present only with DEBOUNCE_STICKY_EN.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
`ifdef DEBOUNCE_STICKY_EN
    input  logic event_clr,
    output logic event_o,
`endif
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   done;

    assign s    = sync[SYNC_STAGES-1];
    assign done = (s != out) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
        end
    end

    // Any cycle where s agrees with out restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            out  <= RESET_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= done & s;
            fall <= done & ~s;
            if (s == out || done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (done) begin
                out <= s;
            end
        end
    end

`ifdef DEBOUNCE_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_o <= 1'b0;
        end else if (rise || fall) begin
            event_o <= 1'b1;
        end else if (event_clr) begin
            event_o <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel input conditioner built from independent debounce_chan slices.
// Define DEBOUNCE_STICKY_EN to add the event_o / event_clr sticky flags.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
`ifdef DEBOUNCE_STICKY_EN
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] event_o,
`endif
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in        (in[i]),
`ifdef DEBOUNCE_STICKY_EN
            .event_clr (event_clr[i]),
            .event_o   (event_o[i]),
`endif
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench: two banks (window 16 and window 4) share one input stream
// and are compared each cycle against a window-based reference model.
module tb_debounce_bank;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SA = 16;
    localparam int SB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in  = '0;
    logic [W-1:0] event_clr = '0;
    logic [W-1:0] out_a, rise_a, fall_a;
    logic [W-1:0] out_b, rise_b, fall_b;
`ifdef DEBOUNCE_STICKY_EN
    logic [W-1:0] ev_a, ev_b;
`endif

    always #5 clk = ~clk;

    debounce_bank #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SA), .RESET_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in(in),
`ifdef DEBOUNCE_STICKY_EN
        .event_clr(event_clr), .event_o(ev_a),
`endif
        .out(out_a), .rise(rise_a), .fall(fall_a)
    );

    debounce_bank #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SB), .RESET_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in(in),
`ifdef DEBOUNCE_STICKY_EN
        .event_clr(event_clr), .event_o(ev_b),
`endif
        .out(out_b), .rise(rise_b), .fall(fall_b)
    );

    typedef struct {
        logic [W-1:0] oa, ra, fa, ea;
        logic [W-1:0] ob, rb, fb, eb;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference model state: input samples per edge since reset release.
    logic [W-1:0] hist[$];
    int           n = 0;
    logic [W-1:0] mo_a = '0, mo_b = '0;
    logic [W-1:0] pr_a = '0, pr_b = '0;
    logic [W-1:0] me_a = '0, me_b = '0;
    int           last_a[W];
    int           last_b[W];

    // Level seen by the filter at edge e: input sampled SS edges earlier.
    function automatic logic s_at(input int e, input int ch);
        logic [W-1:0] h;
        if (e - SS >= 1) begin
            h = hist[e-SS-1];
            return h[ch];
        end
        return 1'b0;
    endfunction

    // out flips at edge n if every edge of the last `stable` since the
    // previous change saw the opposite level.
    function automatic logic flips(input int stable, input logic o, input int last, input int ch);
        for (int k = 0; k < stable; k++) begin
            if (n - k <= last || n - k < 1) return 1'b0;
            if (s_at(n - k, ch) == o) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic [W-1:0] v, input logic [W-1:0] clr);
        exp_t e;
        e = '{default: '0};
        if (r) begin
            hist.delete();
            n = 0;
            mo_a = '0; mo_b = '0;
            pr_a = '0; pr_b = '0;
            me_a = '0; me_b = '0;
            for (int c = 0; c < W; c++) begin
                last_a[c] = 0;
                last_b[c] = 0;
            end
        end else begin
            n++;
            hist.push_back(v);
            me_a = (me_a & ~clr) | pr_a;
            me_b = (me_b & ~clr) | pr_b;
            for (int c = 0; c < W; c++) begin
                if (flips(SA, mo_a[c], last_a[c], c)) begin
                    mo_a[c] = ~mo_a[c];
                    last_a[c] = n;
                    if (mo_a[c]) e.ra[c] = 1'b1;
                    else e.fa[c] = 1'b1;
                end
                if (flips(SB, mo_b[c], last_b[c], c)) begin
                    mo_b[c] = ~mo_b[c];
                    last_b[c] = n;
                    if (mo_b[c]) e.rb[c] = 1'b1;
                    else e.fb[c] = 1'b1;
                end
            end
            pr_a = e.ra | e.fa;
            pr_b = e.rb | e.fb;
        end
        e.oa = mo_a; e.ob = mo_b;
        e.ea = me_a; e.eb = me_b;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t m;
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("out_a", out_a, m.oa);
            chk("rise_a", rise_a, m.ra);
            chk("fall_a", fall_a, m.fa);
            chk("out_b", out_b, m.ob);
            chk("rise_b", rise_b, m.rb);
            chk("fall_b", fall_b, m.fb);
`ifdef DEBOUNCE_STICKY_EN
            chk("event_a", ev_a, m.ea);
            chk("event_b", ev_b, m.eb);
`endif
        end
    end

    task automatic step(input logic [W-1:0] v, input logic r);
        logic [W-1:0] clr;
        clr = '0;
`ifdef DEBOUNCE_STICKY_EN
        clr = W'($urandom & $urandom & $urandom);
`endif
        @(negedge clk);
        in = v;
        rst = r;
        event_clr = clr;
        model_edge(r, v, clr);
    endtask

    task automatic hold(input logic [W-1:0] v, input int cyc);
        for (int i = 0; i < cyc; i++) step(v, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_a", out_a, '0);
        chk("async_rise_a", rise_a, '0);
        chk("async_fall_a", fall_a, '0);
        chk("async_out_b", out_b, '0);
        chk("async_rise_b", rise_b, '0);
        chk("async_fall_b", fall_b, '0);
    endtask

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] v;
        int rate;
        for (int c = 0; c < W; c++) begin
            last_a[c] = 0;
            last_b[c] = 0;
        end
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        hold(4'hF, 25);
        async_reset();
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        hold(4'hF, 25);
        hold(4'h0, 25);
        // clean step on channel 0
        hold(4'h1, 10);
        hold(4'h0, 10);
        // glitch rejection on channel 1
        hold(4'h2, 3);
        hold(4'h0, 10);
        hold(4'h2, 3);
        hold(4'h0, 1);
        hold(4'h2, 10);
        hold(4'h0, 10);
        // channels 0/2 step 2 cycles apart while channel 1 chatters
        for (int i = 0; i < 30; i++) begin
            v = '0;
            if (i >= 2) v[0] = 1'b1;
            if (i >= 4) v[2] = 1'b1;
            v[1] = i[0];
            step(v, 1'b0);
        end
        hold(4'h0, 25);
        // reset in the middle of a count
        hold(4'h8, 10);
        step(4'h8, 1'b1);
        hold(4'h8, 25);
        hold(4'h0, 25);
        // randomized segments with varying toggle rates
        cur = '0;
        for (int seg = 0; seg < 12; seg++) begin
            rate = $urandom_range(1, 14);
            for (int i = 0; i < 40; i++) begin
                for (int c = 0; c < W; c++) begin
                    if ($urandom_range(0, rate - 1) == 0) cur[c] = ~cur[c];
                end
                step(cur, $urandom_range(0, 149) == 0);
            end
        end
        hold(cur, 25);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel input conditioner; successor to the single-bit 3-deep stability shift register.
- Each channel has a multi-stage synchroniser, then a counter-based stability filter with a configurable window.
- Single-cycle rise/fall event pulses per channel.
- Sits between raw board inputs (buttons, switches, async strobes) and the control FSMs in the clk domain.

Parameters:
- WIDTH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flop depth (legal range 2..4).
- STABLE_CYCLES, 16, consecutive cycles a new level must persist before out follows (legal >= 1).
- RESET_LEVEL, 0, level loaded into every synchroniser flop and every out bit on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  raw asynchronous channel inputs.
- out  output  WIDTH  debounced, registered levels.
- rise  output  WIDTH  one-cycle pulse when out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when out[i] goes 1->0.
- event_o  output  WIDTH  sticky change flags; present only with DEBOUNCE_STICKY_EN.
- event_clr  input  WIDTH  per-bit clear for event_o; present only with DEBOUNCE_STICKY_EN.

Behaviour:
- Reset: asynchronous, active-high, applies immediately and regardless of clk.
  - Synchroniser flops = RESET_LEVEL.
  - out = {WIDTH{RESET_LEVEL}}.
  - Counters = 0.
  - rise = fall = 0.
  - event_o = 0.
- Channels are fully independent; there is no cross-channel interaction.
- Synchroniser: in[i] is shifted through SYNC_STAGES flops. s[i] is the last stage.
- Counter width: CW = $clog2(STABLE_CYCLES+1), minimum 1.
- Per channel, each cycle after reset:
  - If s[i] == out[i], cnt <= 0. Any glitch restarts the window.
  - If s[i] != out[i] and cnt == STABLE_CYCLES-1: out[i] <= s[i], cnt <= 0, and rise[i] or fall[i] <= 1 according to direction.
  - If s[i] != out[i] otherwise: cnt <= cnt+1.
- rise/fall: registered, asserted in the same cycle out changes, high for exactly one cycle. rise[i] and fall[i] are never high together.
- Latency: count the first edge sampling the new stable level as edge 1. out changes on edge SYNC_STAGES+STABLE_CYCLES (default 18).
- Boundary conditions:
  - STABLE_CYCLES = 1: out follows s[i] one edge later. This is a pure synchroniser plus register.
  - A pulse shorter than STABLE_CYCLES at s[i] never reaches out and produces no event.
  - Input toggling continuously: out holds its last value indefinitely.
  - Counter never exceeds STABLE_CYCLES-1. No wrap-around is reachable.
  - Reset asserted mid-count: counter is discarded and out returns to RESET_LEVEL. No rise/fall pulse is generated by reset or by its release.
  - After reset release with in == RESET_LEVEL: no events.

Optional Feature:
- Macro: DEBOUNCE_STICKY_EN.
- Defined:
  - event_o[i] sets to 1 on any cycle where rise[i] or fall[i] is asserted.
  - event_o[i] clears when event_clr[i] is 1.
  - Set wins over a simultaneous clear.
  - event_o is registered: the flag appears one cycle after the rise/fall pulse.
- Undefined: event_o, event_clr and their flops are absent. Behaviour is otherwise identical.

Decomposition:
- Package debounce_pkg holds:
  - function cnt_width(stable) returning $clog2(stable+1), minimum 1.
  - localparam defaults: DEF_SYNC_STAGES = 2, DEF_STABLE_CYCLES = 16.
- Sub-module debounce_chan: one channel (synchroniser, counter, out/rise/fall, optional sticky flag).
  - debounce_bank instantiates it WIDTH times in a generate loop and concatenates outputs.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with RESET_LEVEL=0 and in=4'hF held -> out=0, rise=fall=0 immediately. Release rst -> out[3:0] goes to 4'hF on edge 18, with a one-cycle rise=4'hF and no other pulses.
- Clean step (SYNC_STAGES=2, STABLE_CYCLES=4): in[0] 0->1 -> out[0]=1 exactly on edge 6, rise[0] high for 1 cycle only. Then in[0] 1->0 -> fall[0] pulse on edge 6 after the change.
- Glitch reject (STABLE_CYCLES=4): in[1] high for 3 cycles then low -> out[1] stays 0, no rise. in[1] high 3, low 1, high 4 -> single rise after the final 4-cycle run only.
- Independence (WIDTH=4): step in[0] and in[2] 2 cycles apart while in[1] chatters every cycle -> out[0] and out[2] change 2 cycles apart; out[1] and out[3] are unchanged.
- Reset mid-count (STABLE_CYCLES=16): in[3]=1 for 10 cycles, then pulse rst -> counter restarts. out[3] rises 18 edges after release, not 8.
- Sticky (DEBOUNCE_STICKY_EN): rise[2] pulse -> event_o[2]=1 next cycle and held. event_clr[2] asserted in the same cycle as a new fall[2] -> event_o[2] stays 1. event_clr[2] alone -> event_o[2]=0 next cycle.
